// File: rtl/vend_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// vend_sequencer_pkg : coin codes and state encoding for the vending front end
// Rev 1.0
// ============================================================================
package vend_sequencer_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_05   = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_CHANGE   = 2'd2,
    ST_FAULT    = 2'd3
  } vend_state_t;

endpackage
`default_nettype wire

// File: rtl/vend_timeout.sv
`default_nettype none
// ============================================================================
// vend_timeout : clear/enable cycle counter that flags when TIMEOUT is reached
// Rev 1.0
// ============================================================================
module vend_timeout #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

  logic [TO_W-1:0] cnt;

  // Saturates at LIMIT so a stalled wait can never wrap back to "fresh".
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && (cnt != LIMIT))
      cnt <= cnt + TO_W'(1);
  end

  assign expired = en && (cnt == LIMIT);

endmodule
`default_nettype wire

// File: rtl/vend_sequencer.sv
`default_nettype none
// ============================================================================
// vend_sequencer : coin gating, actuator handshakes, stock tracking and fault
// Rev 1.0
// ============================================================================
module vend_sequencer
  import vend_sequencer_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int STOCK_INIT = 8,
  parameter int TO_W       = 8,
  parameter int TIMEOUT    = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       coin_in,
  input  logic             sell,
  input  logic             change,
  input  logic             motor_done,
  input  logic             chg_done,
  input  logic             restock,
  input  logic [CNT_W-1:0] restock_cnt,
  output logic [1:0]       coins_out,
  output logic             coin_reject,
  output logic             motor_req,
  output logic             chg_req,
  output logic             busy,
  output logic             sold_out,
  output logic             fault,
  output logic [CNT_W-1:0] stock
);

  vend_state_t      state, state_n;
  logic             chg_pend, chg_pend_n;
  logic             dec, to_clr, to_en, expired, violation, accept;
  logic [CNT_W-1:0] add, stock_n;
  logic [CNT_W:0]   sum;

  vend_timeout #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (to_clr),
    .en      (to_en),
    .expired (expired)
  );

  assign accept    = (state == ST_IDLE) && !sell && !sold_out;
  assign coins_out = (accept && (coin_in != COIN_BAD)) ? coin_in : COIN_NONE;
  assign violation = (change && !sell) || (sell && (state != ST_IDLE));
  assign to_en     = (state == ST_DISPENSE) || (state == ST_CHANGE);

  always_comb begin
    state_n    = state;
    chg_pend_n = chg_pend;
    dec        = 1'b0;
    to_clr     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (violation) begin
          state_n = ST_FAULT;
        end else if (sell) begin
          state_n    = ST_DISPENSE;
          chg_pend_n = change;
          to_clr     = 1'b1;
        end
      end
      ST_DISPENSE: begin
        if (violation) begin
          state_n = ST_FAULT;
        end else if (motor_done) begin
          dec = 1'b1;
          if (chg_pend) begin
            state_n = ST_CHANGE;
            to_clr  = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (expired) begin
          state_n = ST_FAULT;
        end
      end
      ST_CHANGE: begin
        if (violation) begin
          state_n = ST_FAULT;
        end else if (chg_done) begin
          state_n    = ST_IDLE;
          chg_pend_n = 1'b0;
        end else if (expired) begin
          state_n = ST_FAULT;
        end
      end
      default: state_n = ST_FAULT;
    endcase
  end

  // Decrement is suppressed only when it would underflow an empty stock.
  assign add     = restock ? restock_cnt : '0;
  assign sum     = {1'b0, stock} + {1'b0, add}
                 - {{CNT_W{1'b0}}, (dec && ((stock != '0) || (add != '0)))};
  assign stock_n = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      chg_pend    <= 1'b0;
      stock       <= CNT_W'(STOCK_INIT);
      sold_out    <= (STOCK_INIT == 0);
      coin_reject <= 1'b0;
      motor_req   <= 1'b0;
      chg_req     <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_n;
      chg_pend    <= chg_pend_n;
      stock       <= stock_n;
      sold_out    <= (stock_n == '0);
      coin_reject <= (coin_in != COIN_NONE) && (!accept || (coin_in == COIN_BAD));
      motor_req   <= (state_n == ST_DISPENSE);
      chg_req     <= (state_n == ST_CHANGE);
      busy        <= (state_n != ST_IDLE);
      fault       <= (state_n == ST_FAULT);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vend_sequencer.sv
`default_nettype none
// ============================================================================
// tb_vend_sequencer : directed vector table plus hand sequences for sell-out,
// timeout fault, async reset and protocol violation. Rev 1.0
// ============================================================================
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin_in;
  logic       sell, change, motor_done, chg_done, restock;
  logic [3:0] restock_cnt;
  logic [1:0] coins_out;
  logic       coin_reject, motor_req, chg_req, busy, sold_out, fault;
  logic [3:0] stock;

  int n_tests = 0;
  int n_fail  = 0;

  vend_sequencer #(.CNT_W(4), .STOCK_INIT(8), .TO_W(8), .TIMEOUT(200)) dut (
    .clk         (clk),
    .rst         (rst),
    .coin_in     (coin_in),
    .sell        (sell),
    .change      (change),
    .motor_done  (motor_done),
    .chg_done    (chg_done),
    .restock     (restock),
    .restock_cnt (restock_cnt),
    .coins_out   (coins_out),
    .coin_reject (coin_reject),
    .motor_req   (motor_req),
    .chg_req     (chg_req),
    .busy        (busy),
    .sold_out    (sold_out),
    .fault       (fault),
    .stock       (stock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] coin;
    logic       sel, chg, md, cd, rs;
    logic [3:0] rcnt;
    logic [1:0] e_co;
    logic       e_rej, e_m, e_c, e_busy;
    logic [3:0] e_stock;
  } vec_t;

  function automatic vec_t mk(logic [1:0] coin, logic sel, logic chg, logic md, logic cd,
                              logic rs, logic [3:0] rcnt, logic [1:0] e_co, logic e_rej,
                              logic e_m, logic e_c, logic e_busy, logic [3:0] e_stock);
    vec_t v;
    v.coin = coin; v.sel = sel; v.chg = chg; v.md = md; v.cd = cd; v.rs = rs; v.rcnt = rcnt;
    v.e_co = e_co; v.e_rej = e_rej; v.e_m = e_m; v.e_c = e_c; v.e_busy = e_busy;
    v.e_stock = e_stock;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] c, input logic s, input logic ch, input logic md,
                       input logic cd, input logic rs, input logic [3:0] rc);
    coin_in = c; sell = s; change = ch; motor_done = md; chg_done = cd;
    restock = rs; restock_cnt = rc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sale(input logic [3:0] exp_stock);
    drive(2'b00, 1, 0, 0, 0, 0, 4'd0);
    step();
    chk("sale_req", {7'd0, motor_req}, 8'd1);
    drive(2'b00, 0, 0, 1, 0, 0, 4'd0);
    step();
    chk("sale_stock", {4'd0, stock}, {4'd0, exp_stock});
    chk("sale_soldout", {7'd0, sold_out}, {7'd0, exp_stock == 4'd0});
    drive(2'b00, 0, 0, 0, 0, 0, 4'd0);
  endtask

  vec_t vecs[17];

  initial begin
    //               coin  s  c md cd rs rcnt  co    rej m  c  busy stock
    vecs[0]  = mk(2'b01, 0, 0, 0, 0, 0, 4'd0, 2'b01, 0, 0, 0, 0, 4'd8);
    vecs[1]  = mk(2'b11, 0, 0, 0, 0, 0, 4'd0, 2'b00, 1, 0, 0, 0, 4'd8);
    vecs[2]  = mk(2'b10, 0, 0, 0, 0, 0, 4'd0, 2'b10, 0, 0, 0, 0, 4'd8);
    vecs[3]  = mk(2'b01, 1, 0, 0, 0, 0, 4'd0, 2'b00, 1, 1, 0, 1, 4'd8);
    vecs[4]  = mk(2'b10, 0, 0, 0, 0, 0, 4'd0, 2'b00, 1, 1, 0, 1, 4'd8);
    vecs[5]  = mk(2'b00, 0, 0, 0, 0, 0, 4'd0, 2'b00, 0, 1, 0, 1, 4'd8);
    vecs[6]  = mk(2'b00, 0, 0, 0, 1, 0, 4'd0, 2'b00, 0, 1, 0, 1, 4'd8);
    vecs[7]  = mk(2'b00, 0, 0, 0, 0, 0, 4'd0, 2'b00, 0, 1, 0, 1, 4'd8);
    vecs[8]  = mk(2'b00, 0, 0, 1, 0, 0, 4'd0, 2'b00, 0, 0, 0, 0, 4'd7);
    vecs[9]  = mk(2'b01, 0, 0, 0, 0, 0, 4'd0, 2'b01, 0, 0, 0, 0, 4'd7);
    vecs[10] = mk(2'b00, 1, 1, 0, 0, 0, 4'd0, 2'b00, 0, 1, 0, 1, 4'd7);
    vecs[11] = mk(2'b00, 0, 0, 0, 1, 0, 4'd0, 2'b00, 0, 1, 0, 1, 4'd7);
    vecs[12] = mk(2'b00, 0, 0, 1, 0, 0, 4'd0, 2'b00, 0, 0, 1, 1, 4'd6);
    vecs[13] = mk(2'b00, 0, 0, 1, 0, 0, 4'd0, 2'b00, 0, 0, 1, 1, 4'd6);
    vecs[14] = mk(2'b00, 0, 0, 0, 1, 0, 4'd0, 2'b00, 0, 0, 0, 0, 4'd6);
    vecs[15] = mk(2'b01, 0, 0, 0, 0, 0, 4'd0, 2'b01, 0, 0, 0, 0, 4'd6);
    vecs[16] = mk(2'b00, 0, 0, 0, 0, 1, 4'd3, 2'b00, 0, 0, 0, 0, 4'd9);

    rst = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 0, 4'd0);
    step();
    step();
    chk("rst_flags", {2'd0, coin_reject, motor_req, chg_req, busy, sold_out, fault}, 8'd0);
    chk("rst_stock", {4'd0, stock}, 8'd8);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].coin, vecs[i].sel, vecs[i].chg, vecs[i].md, vecs[i].cd,
            vecs[i].rs, vecs[i].rcnt);
      #3;
      chk($sformatf("v%0d_coins_out", i), {6'd0, coins_out}, {6'd0, vecs[i].e_co});
      step();
      chk($sformatf("v%0d_reject", i), {7'd0, coin_reject}, {7'd0, vecs[i].e_rej});
      chk($sformatf("v%0d_motor_req", i), {7'd0, motor_req}, {7'd0, vecs[i].e_m});
      chk($sformatf("v%0d_chg_req", i), {7'd0, chg_req}, {7'd0, vecs[i].e_c});
      chk($sformatf("v%0d_busy", i), {7'd0, busy}, {7'd0, vecs[i].e_busy});
      chk($sformatf("v%0d_stock", i), {4'd0, stock}, {4'd0, vecs[i].e_stock});
    end

    // Restock saturates at 15, then sell down to empty.
    drive(2'b00, 0, 0, 0, 0, 1, 4'd15);
    step();
    chk("restock_sat", {4'd0, stock}, 8'd15);
    drive(2'b00, 0, 0, 0, 0, 0, 4'd0);
    for (int s = 14; s >= 0; s--) sale(4'(s));

    drive(2'b01, 0, 0, 0, 0, 0, 4'd0);
    #3;
    chk("soldout_coins_out", {6'd0, coins_out}, 8'd0);
    step();
    chk("soldout_reject", {7'd0, coin_reject}, 8'd1);

    // Sale with no motor ack: FAULT exactly TIMEOUT+1 cycles after motor_req rises.
    drive(2'b00, 1, 0, 0, 0, 0, 4'd0);
    step();
    chk("to_req", {7'd0, motor_req}, 8'd1);
    drive(2'b00, 0, 0, 0, 0, 0, 4'd0);
    repeat (200) step();
    chk("to_before", {6'd0, fault, motor_req}, 8'd1);
    step();
    chk("to_fault", {5'd0, fault, motor_req, busy}, 8'b101);
    drive(2'b01, 0, 0, 0, 0, 1, 4'd15);
    #3;
    chk("fault_coins_out", {6'd0, coins_out}, 8'd0);
    step();
    chk("fault_reject", {7'd0, coin_reject}, 8'd1);
    chk("fault_restock", {4'd0, stock}, 8'd15);
    chk("fault_sticky", {6'd0, fault, sold_out}, 8'b10);
    drive(2'b00, 0, 0, 0, 0, 0, 4'd0);

    rst = 1'b1;
    #2;
    chk("async_rst_flags", {4'd0, fault, busy, motor_req, chg_req}, 8'd0);
    chk("async_rst_stock", {4'd0, stock}, 8'd8);
    step();
    rst = 1'b0;

    // change without sell is a protocol violation.
    drive(2'b00, 0, 1, 0, 0, 0, 4'd0);
    step();
    chk("proto_fault", {7'd0, fault}, 8'd1);
    drive(2'b00, 0, 0, 0, 0, 0, 4'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("final_idle", {6'd0, fault, busy}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
